// File: rtl/scan_bist_seq.sv
// scan_bist_seq: scan-based logic BIST sequencer (LFSR -> scan chain -> MISR -> signature compare).
// Define SCAN_BIST_SIG_OUT_EN to expose the live MISR (signature) and pattern counter (pattern_cnt).
module scan_bist_seq #(
  parameter int                CHAIN_LEN  = 9,
  parameter int                N_PATTERNS = 100,
  parameter int                PO_W       = 9,
  parameter int                MISR_W     = 16,
  parameter logic [MISR_W-1:0] MISR_POLY  = 16'h1021,
  parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bist_start,
  input  logic            lfsr_si,
  input  logic            scan_out,
  input  logic [PO_W-1:0] po,
  output logic            lfsr_reset,
  output logic            lfsr_si_en,
  output logic            lfsr_pi_en,
  output logic            cut_reset,
  output logic            scan_en,
  output logic            scan_in,
  output logic            running,
  output logic            bist_end,
  output logic            pass_nfail
`ifdef SCAN_BIST_SIG_OUT_EN
  ,
  output logic [MISR_W-1:0] signature,
  output logic [15:0]       pattern_cnt
`endif
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INIT    = 3'd1;
  localparam logic [2:0] SHIFT   = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] FLUSH   = 3'd4;
  localparam logic [2:0] COMPARE = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;
  localparam logic [7:0]  LAST_BIT = 8'(CHAIN_LEN - 1);
  localparam logic [15:0] LAST_PAT = 16'(N_PATTERNS - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        bit_q, bit_d;
  logic [15:0]       pat_q, pat_d;
  logic [MISR_W-1:0] misr_q, misr_d, misr_in;
  logic              prev_q, pass_q, pass_d;
  logic              start_pulse, bit_last, compacting;

  assign start_pulse = bist_start & ~prev_q;
  assign bit_last    = bit_q == LAST_BIT;
  assign compacting  = state_q == SHIFT || state_q == CAPTURE || state_q == FLUSH;
  assign misr_in     = state_q == CAPTURE ? MISR_W'(po) : MISR_W'(scan_out);

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    pat_d   = pat_q;
    pass_d  = pass_q;
    misr_d  = compacting ? {misr_q[MISR_W-2:0], 1'b0} ^ (misr_q[MISR_W-1] ? MISR_POLY : '0) ^ misr_in : misr_q;
    case (state_q)
      IDLE, DONE: state_d = start_pulse ? INIT : state_q;
      INIT: begin
        state_d = SHIFT;
        bit_d   = '0;
        pat_d   = '0;
        misr_d  = '0;
      end
      SHIFT, FLUSH: begin
        bit_d   = bit_last ? '0 : bit_q + 8'd1;
        state_d = !bit_last ? state_q : state_q == SHIFT ? CAPTURE : COMPARE;
      end
      CAPTURE: begin
        pat_d   = pat_q + 16'd1;
        state_d = pat_q == LAST_PAT ? FLUSH : SHIFT;
      end
      COMPARE: begin
        pass_d  = misr_q == GOLDEN_SIG;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    pass_d = state_d == INIT ? 1'b0 : pass_d;
  end

  // prev_q resets high so a start held through reset is not seen as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      pat_q   <= '0;
      misr_q  <= '0;
      prev_q  <= 1'b1;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      pat_q   <= pat_d;
      misr_q  <= misr_d;
      prev_q  <= bist_start;
      pass_q  <= pass_d;
    end
  end

  assign lfsr_reset = state_q == INIT;
  assign cut_reset  = state_q == INIT;
  assign lfsr_si_en = state_q == SHIFT;
  assign lfsr_pi_en = state_q == CAPTURE;
  assign scan_en    = state_q == SHIFT || state_q == FLUSH;
  assign scan_in    = state_q == SHIFT && lfsr_si;
  assign running    = state_q != IDLE && state_q != DONE;
  assign bist_end   = state_q == DONE;
  assign pass_nfail = pass_q;
`ifdef SCAN_BIST_SIG_OUT_EN
  assign signature   = misr_q;
  assign pattern_cnt = pat_q;
`endif
endmodule

// File: tb/tb_scan_bist_seq.sv
// tb_scan_bist_seq: directed bench for scan_bist_seq, instance a (4 bits x 3 patterns) and b (1 x 1).
module tb_scan_bist_seq;
  function automatic logic so_fn(int k);
    return ((k * 11) % 7) > 3;
  endfunction

  function automatic logic [8:0] po_fn(int k);
    return 9'((k * 37 + 11) % 512);
  endfunction

  // Signature of a run whose start edge is E0; edge e sees so_fn(e)/po_fn(e)
  function automatic logic [15:0] gold(int c, int n, int inv_k);
    logic [15:0] m;
    logic [15:0] d;
    int r;
    m = '0;
    for (int e = 2; e <= 1 + n * (c + 1) + c; e++) begin
      r = e - 2;
      if (r < n * (c + 1) && r % (c + 1) == c) d = 16'(po_fn(e));
      else d = 16'(so_fn(e) ^ (e == inv_k));
      m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ d;
    end
    return m;
  endfunction

  localparam logic [15:0] GA = gold(4, 3, -1);
  localparam logic [15:0] GB = gold(1, 1, -1);

  logic       clk, reset, bist_start, lfsr_si, scan_out, sel;
  logic [8:0] po;
  logic a_lfsr_reset, a_lfsr_si_en, a_lfsr_pi_en, a_cut_reset, a_scan_en, a_scan_in, a_running, a_bist_end, a_pass;
  logic b_lfsr_reset, b_lfsr_si_en, b_lfsr_pi_en, b_cut_reset, b_scan_en, b_scan_in, b_running, b_bist_end, b_pass;
  logic [7:0] a_vec, b_vec, o_vec;
  logic       o_pass;
  int tests, fails;
`ifdef SCAN_BIST_SIG_OUT_EN
  logic [15:0] a_sig, b_sig, a_pc, b_pc;
`endif

  scan_bist_seq #(.CHAIN_LEN(4), .N_PATTERNS(3), .GOLDEN_SIG(GA)) u_a (
    .clk(clk), .reset(reset), .bist_start(bist_start), .lfsr_si(lfsr_si), .scan_out(scan_out), .po(po),
    .lfsr_reset(a_lfsr_reset), .lfsr_si_en(a_lfsr_si_en), .lfsr_pi_en(a_lfsr_pi_en), .cut_reset(a_cut_reset),
    .scan_en(a_scan_en), .scan_in(a_scan_in), .running(a_running), .bist_end(a_bist_end), .pass_nfail(a_pass)
`ifdef SCAN_BIST_SIG_OUT_EN
    , .signature(a_sig), .pattern_cnt(a_pc)
`endif
  );

  scan_bist_seq #(.CHAIN_LEN(1), .N_PATTERNS(1), .GOLDEN_SIG(GB)) u_b (
    .clk(clk), .reset(reset), .bist_start(bist_start), .lfsr_si(lfsr_si), .scan_out(scan_out), .po(po),
    .lfsr_reset(b_lfsr_reset), .lfsr_si_en(b_lfsr_si_en), .lfsr_pi_en(b_lfsr_pi_en), .cut_reset(b_cut_reset),
    .scan_en(b_scan_en), .scan_in(b_scan_in), .running(b_running), .bist_end(b_bist_end), .pass_nfail(b_pass)
`ifdef SCAN_BIST_SIG_OUT_EN
    , .signature(b_sig), .pattern_cnt(b_pc)
`endif
  );

  // Vector order: running, scan_en, scan_in, lfsr_si_en, lfsr_pi_en, lfsr_reset, cut_reset, bist_end
  assign a_vec  = {a_running, a_scan_en, a_scan_in, a_lfsr_si_en, a_lfsr_pi_en, a_lfsr_reset, a_cut_reset, a_bist_end};
  assign b_vec  = {b_running, b_scan_en, b_scan_in, b_lfsr_si_en, b_lfsr_pi_en, b_lfsr_reset, b_cut_reset, b_bist_end};
  assign o_vec  = sel ? b_vec : a_vec;
  assign o_pass = sel ? b_pass : a_pass;

  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({a_vec, a_pass, b_vec, b_pass} !== 18'b0) begin
      fails++;
      $display("FAIL reset_held: got %b/%b %b/%b expected all 0", a_vec, a_pass, b_vec, b_pass);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({a_vec, a_pass, b_vec, b_pass} !== 18'b0) begin
        fails++;
        $display("FAIL reset_release_start_high cyc %0d: got %b/%b %b/%b expected all 0", i, a_vec, a_pass, b_vec, b_pass);
      end
    end
  endtask

  task automatic do_run(input string nm, input int c, input int n, input int inv_k, input bit noise,
                        input bit exp_pass, input int exp_end, input int exp_scan, input int exp_pi);
    int end_j, first_end, n_scan, n_pi, j, r;
    logic [7:0] exp_v;
    end_j = 2 + n * (c + 1) + c;
    first_end = -1;
    n_scan = 0;
    n_pi = 0;
    @(negedge clk);
    bist_start = 1'b0;
    @(negedge clk);
    tests++;
    if (o_vec[7] !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_before: running got %b expected 0", nm, o_vec[7]);
    end
    bist_start = 1'b1;
    lfsr_si = 1'b0;
    scan_out = so_fn(0);
    po = po_fn(0);
    for (int k = 1; k <= end_j + 1; k++) begin
      @(negedge clk);
      j = k - 1;
      r = j - 1;
      if (j == 0) exp_v = 8'b1000_0110;
      else if (r < n * (c + 1) && r % (c + 1) < c) exp_v = {2'b11, lfsr_si, 5'b1_0000};
      else if (r < n * (c + 1)) exp_v = 8'b1000_1000;
      else if (r < n * (c + 1) + c) exp_v = 8'b1100_0000;
      else if (r == n * (c + 1) + c) exp_v = 8'b1000_0000;
      else exp_v = 8'b0000_0001;
      tests++;
      if (o_vec !== exp_v) begin
        fails++;
        $display("FAIL %s outputs after E%0d: got %b expected %b", nm, j, o_vec, exp_v);
      end
      tests++;
      if (o_pass !== (j == end_j ? exp_pass : 1'b0)) begin
        fails++;
        $display("FAIL %s pass_nfail after E%0d: got %b expected %b", nm, j, o_pass, j == end_j ? exp_pass : 1'b0);
      end
      n_scan += int'(o_vec[6]);
      n_pi += int'(o_vec[3]);
      if (o_vec[0] === 1'b1 && first_end < 0) first_end = j;
      lfsr_si = logic'(k % 2);
      bist_start = noise ? (k % 3 != 0 && k < end_j - 2) : (k < 3);
      scan_out = so_fn(k) ^ (k == inv_k);
      po = po_fn(k);
    end
    tests++;
    if (first_end != exp_end) begin
      fails++;
      $display("FAIL %s bist_end_latency: got E%0d expected E%0d", nm, first_end, exp_end);
    end
    tests++;
    if (n_scan != exp_scan) begin
      fails++;
      $display("FAIL %s scan_en_cycles: got %0d expected %0d", nm, n_scan, exp_scan);
    end
    tests++;
    if (n_pi != exp_pi) begin
      fails++;
      $display("FAIL %s lfsr_pi_en_pulses: got %0d expected %0d", nm, n_pi, exp_pi);
    end
    repeat (2) @(negedge clk);
    tests++;
    if ({o_vec[0], o_pass} !== {1'b1, exp_pass}) begin
      fails++;
      $display("FAIL %s done_hold: got end=%b pass=%b expected end=1 pass=%b", nm, o_vec[0], o_pass, exp_pass);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    sel = 1'b0;
    @(negedge clk);
    bist_start = 1'b0;
    @(negedge clk);
    bist_start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      bist_start = k < 3;
      scan_out = so_fn(k);
      po = po_fn(k);
    end
    tests++;
    if (a_vec[6] !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid in_shift: scan_en got %b expected 1", a_vec[6]);
    end
    bist_start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_vec, a_pass} !== 9'b0) begin
      fails++;
      $display("FAIL reset_mid outputs: got %b/%b expected all 0", a_vec, a_pass);
    end
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (a_vec[0] !== 1'b0 || a_vec[7] !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL reset_mid idle_after: running/bist_end got 1 expected 0");
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0;
    reset = 1'b1;
    bist_start = 1'b1;
    lfsr_si = 1'b0;
    scan_out = 1'b0;
    po = '0;
    sel = 1'b0;
    test_reset();
    do_run("timing", 4, 3, -1, 1'b0, 1'b1, 21, 16, 3);
    do_run("rerun", 4, 3, -1, 1'b0, 1'b1, 21, 16, 3);
    do_run("noise", 4, 3, -1, 1'b1, 1'b1, 21, 16, 3);
    do_run("fail", 4, 3, 7, 1'b0, 1'b0, 21, 16, 3);
    do_run("pass_again", 4, 3, -1, 1'b0, 1'b1, 21, 16, 3);
    test_reset_mid();
    sel = 1'b1;
    do_run("corner", 1, 1, -1, 1'b0, 1'b1, 5, 2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/scan_bist_seq.md
Name: scan_bist_seq

Overview:
- Sequencer for scan-based logic BIST of the scan-inserted CUT (circuito09_scan_syn).
- On a rising edge of bist_start it:
  - resets the pattern LFSRs and the CUT;
  - shifts LFSR bits into the scan chain, fires one capture cycle, and repeats for N_PATTERNS patterns;
  - compacts scan_out and the CUT primary outputs into a MISR, then compares the MISR against a golden signature.
- Sits in top_level between the LFSRs and the CUT, and drives bist_end and pass_nfail.

Parameters:
- CHAIN_LEN, 9: scan chain length in flops; range 1..255.
- N_PATTERNS, 100: patterns applied per run; range 1..65535.
- PO_W, 9: CUT primary-output width compacted at capture; must be < MISR_W.
- MISR_W, 16: MISR width.
- MISR_POLY, 16'h1021: MISR feedback polynomial; bit i set means tap i.
- GOLDEN_SIG, 16'h0000: expected final MISR value.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- bist_start  in  1  run request; rising-edge triggered.
- lfsr_si  in  1  scan-in source bit (9b LFSR bit 0).
- scan_out  in  1  CUT scan chain output.
- po  in  PO_W  CUT primary outputs.
- lfsr_reset  out  1  LFSR synchronous reset.
- lfsr_si_en  out  1  advance the 9b LFSR.
- lfsr_pi_en  out  1  advance the 7b (primary-input) LFSR.
- cut_reset  out  1  CUT reset.
- scan_en  out  1  CUT scan enable.
- scan_in  out  1  CUT scan input.
- running  out  1  high from INIT through COMPARE.
- bist_end  out  1  high in DONE.
- pass_nfail  out  1  1 = signature matched; valid while bist_end is 1.

Behaviour:
- Reset (takes priority in any state):
  - state becomes IDLE; bit and pattern counters become 0; MISR becomes 0.
  - prev_start becomes 1, so a bist_start held high through reset does not trigger a run.
  - All outputs 0.
- Start detect: start_pulse = bist_start & ~prev_start. prev_start is registered every cycle.
- States and transitions:
  - IDLE: on start_pulse go to INIT.
  - INIT (1 cycle): lfsr_reset=1, cut_reset=1. MISR and both counters are cleared. Go to SHIFT.
  - SHIFT (CHAIN_LEN cycles):
    - scan_en=1, scan_in=lfsr_si, lfsr_si_en=1.
    - MISR compacts D = {zeros, scan_out}.
    - Bit counter counts 0..CHAIN_LEN-1; at CHAIN_LEN-1 it clears and the FSM goes to CAPTURE.
  - CAPTURE (1 cycle):
    - scan_en=0, lfsr_pi_en=1.
    - MISR compacts D = zero-extended po.
    - Pattern counter increments.
    - If pattern counter = N_PATTERNS-1 before the increment, go to FLUSH; otherwise go to SHIFT.
  - FLUSH (CHAIN_LEN cycles): as SHIFT, except scan_in=0 and lfsr_si_en=0. Then go to COMPARE.
  - COMPARE (1 cycle): pass_nfail <= (MISR == GOLDEN_SIG). Go to DONE.
  - DONE: bist_end=1; pass_nfail is held. On start_pulse go to INIT, clearing bist_end and pass_nfail.
- MISR update: misr <= {misr[MISR_W-2:0],1'b0} ^ (misr[MISR_W-1] ? MISR_POLY : 0) ^ D. It holds in states other than SHIFT, CAPTURE and FLUSH.
- running is 1 in INIT, SHIFT, CAPTURE, FLUSH and COMPARE.
- A start_pulse while running is ignored.
- Latency: edge E0 samples start_pulse.
  - bist_end first rises after edge E(1 + N_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1).
  - scan_en is high for (N_PATTERNS+1)*CHAIN_LEN cycles in total.
- Counter widths: bit counter 8 bits, pattern counter 16 bits. Counters never wrap, because termination is an equality compare.
- All outputs are registered or decoded from the state register only; none depend combinationally on inputs except scan_in, which follows lfsr_si in SHIFT.

Optional Feature:
- Macro: SCAN_BIST_SIG_OUT_EN.
- Defined:
  - Adds output port signature [MISR_W-1:0], equal to the live MISR register.
  - Adds output port pattern_cnt [15:0], equal to the live pattern counter.
  - Both read 0 under reset.
- Undefined: these ports are absent; all other behaviour is identical.

Test Plan:
- Reset: assert reset for 2 cycles with bist_start=1, then release while holding bist_start=1. All outputs must stay 0 and the state must stay IDLE.
- Timing with CHAIN_LEN=4, N_PATTERNS=3: pulse bist_start.
  - running rises after E0; bist_end rises after E21.
  - scan_en must be high for exactly 16 cycles; lfsr_pi_en must pulse exactly 3 times.
  - scan_in must be 0 throughout the final 4 shift cycles.
- Pass/fail: drive scan_out and po from a reference model and set GOLDEN_SIG to the model signature; the run must end with pass_nfail=1. Invert scan_out for one SHIFT cycle; the run must end with pass_nfail=0.
- Reset mid-SHIFT, with bist_start low at release: assert reset on pattern 2, bit 1. The next cycle must show all outputs 0, and bist_end must never assert.
- Noise and rerun: toggle bist_start during the run; the run length must be unchanged. After DONE, a new rising edge must clear bist_end for one run and reproduce an identical signature and pass_nfail.
- Parameter corner CHAIN_LEN=1, N_PATTERNS=1: bist_end must rise after E5, with scan_en high for exactly 2 cycles.
